// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift left / shift right / parallel load,
// plus an automatic burst of WIDTH shifts launched by start.
module universal_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  logic             dir;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_shl;
  logic [WIDTH-1:0] q_shr;

  assign q_shl = {q[WIDTH-2:0], sin};
  assign q_shr = {sin, q[WIDTH-1:1]};

  // Serial output follows the last shift direction with no added latency
  assign sout = dir ? q[0] : q[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= RST_VAL;
      dir   <= 1'b0;
      cnt   <= '0;
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            if (start && (mode == MODE_LEFT || mode == MODE_RIGHT)) begin
              // Accepting a burst takes no shift on this edge
              dir   <= (mode == MODE_RIGHT);
              cnt   <= CNT_W'(WIDTH);
              state <= SHIFT;
              busy  <= 1'b1;
            end else begin
              case (mode)
                MODE_LEFT: begin
                  q   <= q_shl;
                  dir <= 1'b0;
                end
                MODE_RIGHT: begin
                  q   <= q_shr;
                  dir <= 1'b1;
                end
                MODE_LOAD: q <= d;
                MODE_HOLD: q <= q;
                default:   q <= q;
              endcase
            end
          end
        end
        SHIFT: begin
          if (en) begin
            q   <= dir ? q_shr : q_shl;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          // Completion pulse lasts exactly one cycle regardless of en
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8, RST_VAL=0): a cycle
// model checked every edge plus directed literal expectations.
module tb_universal_shift_reg;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic [1:0]   mode = 2'b11;
  logic [W-1:0] d = 8'hA5;
  logic         sin = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] q;
  logic         sout;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  universal_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
    .start(start), .q(q), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: register value, last direction, shifts remaining in a burst,
  // and whether this cycle is the completion cycle.
  int  m_val;
  bit  m_right;
  int  m_left_shifts;
  bit  m_in_burst;
  bit  m_done;
  bit  m_valid = 0;

  function automatic int shift_val(int v, bit right, bit s);
    if (right) return (v >> 1) + (s ? 128 : 0);
    return ((v * 2) % 256) + (s ? 1 : 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_val = 0; m_right = 0; m_left_shifts = 0;
      m_in_burst = 0; m_done = 0; m_valid = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (en && m_in_burst) begin
      m_val = shift_val(m_val, m_right, sin);
      m_left_shifts = m_left_shifts - 1;
      if (m_left_shifts == 0) begin
        m_in_burst = 0;
        m_done = 1;
      end
    end else if (en) begin
      if (start && (mode == 2'd1 || mode == 2'd2)) begin
        m_right = (mode == 2'd2);
        m_left_shifts = W;
        m_in_burst = 1;
      end else if (mode == 2'd1) begin
        m_val = shift_val(m_val, 0, sin); m_right = 0;
      end else if (mode == 2'd2) begin
        m_val = shift_val(m_val, 1, sin); m_right = 1;
      end else if (mode == 2'd3) begin
        m_val = int'(d);
      end
    end
    #1;
    if (m_valid) begin
      check("model_q", int'(q), m_val);
      check("model_busy", int'(busy), int'(m_in_burst));
      check("model_done", int'(done), int'(m_done));
      check("model_sout", int'(sout), m_right ? (m_val % 2) : (m_val / 128));
    end
  end

  // Advance one edge; inputs change 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int          off;
  logic [7:0]  pat;

  initial begin
    // Reset with load requested: reset wins
    step();
    check("rst_q", int'(q), 8'h00);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sout", int'(sout), 0);

    rst = 0; mode = 2'b11; d = 8'hA5;
    step();
    check("load_a5", int'(q), 8'hA5);
    mode = 2'b00;
    repeat (3) step();
    check("hold_a5", int'(q), 8'hA5);

    // en low freezes a load
    en = 0; mode = 2'b11; d = 8'h3C;
    step();
    check("en0_hold", int'(q), 8'hA5);
    en = 1;

    mode = 2'b01; sin = 1;
    #1 check("sout_before_left", int'(sout), 1);
    step();
    check("left_4b", int'(q), 8'h4B);
    mode = 2'b10; sin = 0;
    step();
    check("right_25", int'(q), 8'h25);

    // Burst right from 0x81; start/mode/d during burst must be ignored
    mode = 2'b11; d = 8'h81;
    step();
    check("load_81", int'(q), 8'h81);
    start = 1; mode = 2'b10; sin = 0;
    step();
    check("accept_busy", int'(busy), 1);
    check("accept_noshift", int'(q), 8'h81);
    mode = 2'b11; d = 8'hFF;
    off = 0; pat = '0;
    for (int i = 1; i <= 20; i++) begin
      if (i <= 8) pat = {pat[6:0], sout};
      step();
      if (done) begin off = i; break; end
    end
    start = 0; mode = 2'b00;
    check("burst_done_edge", off, 8);
    check("burst_sout_seq", int'(pat), 8'b1000_0001);
    check("burst_final_q", int'(q), 8'h00);
    step();
    check("done_one_cycle", int'(done), 0);

    // Same burst with a 3-cycle stall after the 3rd shift
    mode = 2'b11; d = 8'h81;
    step();
    start = 1; mode = 2'b10; sin = 0;
    step();
    start = 0; mode = 2'b00;
    off = 0;
    for (int i = 1; i <= 30; i++) begin
      en = (i >= 4 && i <= 6) ? 1'b0 : 1'b1;
      step();
      if (i >= 4 && i <= 6) check("stall_q", int'(q), 8'h10);
      if (done) begin off = i; break; end
    end
    en = 1;
    check("stall_done_edge", off, 11);
    step();

    // Reset after the 4th shift aborts the burst
    mode = 2'b11; d = 8'h81;
    step();
    start = 1; mode = 2'b10;
    step();
    start = 0; mode = 2'b00;
    repeat (4) step();
    check("pre_abort_q", int'(q), 8'h08);
    rst = 1;
    step();
    rst = 0;
    check("abort_q", int'(q), 8'h00);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    start = 1; mode = 2'b01; sin = 1;
    step();
    check("restart_busy", int'(busy), 1);
    start = 0; mode = 2'b00;
    off = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) begin off = i; break; end
    end
    check("restart_done_edge", off, 8);
    check("restart_q", int'(q), 8'hFF);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter RST_VAL, default {WIDTH{1'b0}}, value loaded into q on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  clock enable; low freezes all state.
REQ-006 SHALL have port mode  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load.
REQ-007 SHALL have port d  input  WIDTH  parallel load data.
REQ-008 SHALL have port sin  input  1  serial input bit.
REQ-009 SHALL have port start  input  1  request for an automatic burst of WIDTH shifts.
REQ-010 SHALL have port q  output  WIDTH  register contents (registered).
REQ-011 SHALL have port sout  output  1  serial output: q[WIDTH-1] when dir=left, q[0] when dir=right.
REQ-012 SHALL have port busy  output  1  high while the burst is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse on burst completion.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE, plus an internal dir bit (0 = left, 1 = right) and a shift counter of width clog2(WIDTH+1).
REQ-015 In IDLE with en=1 and start=0, the block SHALL apply mode on each edge:
- hold: q unchanged.
- left: q <= {q[WIDTH-2:0], sin}; dir <= 0.
- right: q <= {sin, q[WIDTH-1:1]}; dir <= 1.
- load: q <= d; dir unchanged.
REQ-016 In IDLE with en=1, start=1 and mode 01 or 10, the block SHALL take no shift that edge, set dir from mode, load counter=WIDTH and enter SHIFT.
REQ-017 In IDLE, start=1 with mode 00 or 11 SHALL be treated as start=0.
REQ-018 In SHIFT with en=1, the block SHALL perform one shift per edge in direction dir using sin, and decrement the counter; on the edge where the counter reaches 0 it SHALL enter DONE.
REQ-019 Latency: with start accepted at edge k, shifts SHALL occur at edges k+1..k+WIDTH, and done SHALL be high exactly from edge k+WIDTH to edge k+WIDTH+1.
REQ-020 DONE SHALL last one cycle with q held, then return to IDLE unconditionally; done = (state==DONE).
REQ-021 busy SHALL equal (state==SHIFT).
REQ-022 mode, d and start SHALL be ignored in SHIFT and DONE; a new start SHALL be accepted only in IDLE.
REQ-023 With en=0, q, dir, counter and state SHALL hold (DONE excepted per REQ-020); the burst SHALL resume from where it stopped when en returns high.
REQ-024 sout SHALL be combinational from q and dir, with no added latency.

Reset
REQ-025 On a rising edge with rst=1, the block SHALL set q=RST_VAL, dir=0, counter=0, state=IDLE, busy=0, done=0, overriding en, start and mode.
REQ-026 Reset mid-burst SHALL abort the burst with no done pulse; a start on the first cycle after rst deasserts SHALL be accepted.

Verification (WIDTH=8, RST_VAL=0)
REQ-027 rst=1, en=1, mode=11, d=8'hA5 for one edge -> q=8'h00, busy=0, done=0, sout=0.
REQ-028 en=1, mode=11, d=8'hA5 -> q=8'hA5 after one edge; then mode=00 for 3 edges -> q stays 8'hA5.
REQ-029 q=8'hA5, mode=01, sin=1 -> sout=1 before the edge, q=8'h4B after it; then mode=10, sin=0 -> q=8'h25.
REQ-030 Burst right from q=8'h81: start=1, mode=10, sin=0 -> busy for 8 cycles; sout sampled before each shift edge = 1,0,0,0,0,0,0,1; final q=8'h00; single done pulse at edge k+8.
REQ-031 Same burst with en=0 for 3 cycles after the 3rd shift -> q frozen at 8'h10 during the stall; done arrives 3 cycles later than in REQ-030.
REQ-032 rst=1 after the 4th burst shift -> q=8'h00, busy=0, no done pulse; start on the next cycle -> busy high after one edge.
